// File: rtl/bp_trace_delta_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : bp_trace_delta_encoder
//  Purpose  : Passive commit-stream snooper that compresses committed PCs into
//             64-bit trace packets. Sequential commits only bump a run
//             counter. A PC discontinuity emits a BRANCH packet carrying the
//             run length and the new PC. Packets queue in a small FIFO ahead
//             of the trace sink. On FIFO overflow, dropped commits are counted
//             and reported with an OVERFLOW packet, and the stream then
//             resynchronises with a fresh SYNC packet.
//  Ports    : clk_i / reset_n_i        clock, asynchronous active-low reset
//             commit_v_i/commit_ready_i commit handshake (never backpressured)
//             commit_pc_i              PC of the committed instruction
//             flush_i                  request to emit any pending run
//             trace_data_o/trace_v_o   packet at the FIFO head, head valid
//             trace_ready_i            sink accepts the head packet
//             overflow_o               high while commits are being dropped
//  Revision : 1.0 - initial release
// ============================================================================
module bp_trace_delta_encoder #(
    parameter int vaddr_width_p = 40,
    parameter int run_width_p   = 16,
    parameter int drop_width_p  = 16,
    parameter int fifo_els_p    = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     commit_v_i,
    input  logic                     commit_ready_i,
    input  logic [vaddr_width_p-1:0] commit_pc_i,
    input  logic                     flush_i,
    output logic [63:0]              trace_data_o,
    output logic                     trace_v_o,
    input  logic                     trace_ready_i,
    output logic                     overflow_o
);

    localparam int c_PW = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int c_CW = c_PW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(fifo_els_p);

    localparam logic [1:0] c_ST_SYNC  = 2'd0;
    localparam logic [1:0] c_ST_TRACE = 2'd1;
    localparam logic [1:0] c_ST_DROP  = 2'd2;

    localparam logic [1:0] c_PT_SYNC     = 2'b00;
    localparam logic [1:0] c_PT_RUN      = 2'b01;
    localparam logic [1:0] c_PT_BRANCH   = 2'b10;
    localparam logic [1:0] c_PT_OVERFLOW = 2'b11;

    // The run counter never holds all-ones: the commit that would take it
    // there emits a saturated RUN packet instead and restarts the count.
    localparam logic [run_width_p-1:0] c_RUN_LAST = {{(run_width_p-1){1'b1}}, 1'b0};

    logic [1:0]               r_state;
    logic [run_width_p-1:0]   r_run;
    logic [vaddr_width_p-1:0] r_last_pc;
    logic [drop_width_p-1:0]  r_drop;

    logic [63:0]              r_mem [fifo_els_p];
    logic [c_PW-1:0]          r_wptr;
    logic [c_PW-1:0]          r_rptr;
    logic [c_CW-1:0]          r_count;

    logic                     w_accept;
    logic                     w_seq;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_enq;
    logic                     w_deq;
    logic                     w_gen;
    logic [63:0]              w_pkt;
    logic [1:0]               w_state_nxt;
    logic [run_width_p-1:0]   w_run_nxt;
    logic [vaddr_width_p-1:0] w_last_pc_nxt;
    logic [drop_width_p-1:0]  w_drop_nxt;
    logic [drop_width_p-1:0]  w_drop_inc;

    assign w_accept   = commit_v_i & commit_ready_i;
    // Modular add, so the top of the address space wraps into 0 sequentially.
    assign w_seq      = (commit_pc_i == (r_last_pc + vaddr_width_p'(4)));
    // Full is judged on the registered count only: a same-cycle dequeue
    // does not make room for this cycle's write.
    assign w_full     = (r_count == c_FULL);
    assign w_empty    = (r_count == '0);
    assign w_deq      = ~w_empty & trace_ready_i;
    assign w_enq      = w_gen & ~w_full;
    assign w_drop_inc = (r_drop == '1) ? r_drop : (r_drop + drop_width_p'(1));

    always_comb begin
        w_gen         = 1'b0;
        w_pkt         = '0;
        w_state_nxt   = r_state;
        w_run_nxt     = r_run;
        w_last_pc_nxt = r_last_pc;
        w_drop_nxt    = r_drop;
        case (r_state)
            c_ST_SYNC: begin
                if (w_accept) begin
                    w_gen                        = 1'b1;
                    w_pkt[63:62]                 = c_PT_SYNC;
                    w_pkt[vaddr_width_p-1:0]     = commit_pc_i;
                    w_last_pc_nxt                = commit_pc_i;
                    w_run_nxt                    = '0;
                    w_state_nxt                  = c_ST_TRACE;
                end
            end
            c_ST_TRACE: begin
                if (w_accept) begin
                    w_last_pc_nxt = commit_pc_i;
                    if (w_seq) begin
                        if (r_run == c_RUN_LAST) begin
                            w_gen                  = 1'b1;
                            w_pkt[63:62]           = c_PT_RUN;
                            w_pkt[run_width_p-1:0] = '1;
                            w_run_nxt              = '0;
                        end else begin
                            w_run_nxt = r_run + run_width_p'(1);
                        end
                    end else begin
                        w_gen                                 = 1'b1;
                        w_pkt[63:62]                          = c_PT_BRANCH;
                        w_pkt[vaddr_width_p-1:0]              = commit_pc_i;
                        w_pkt[vaddr_width_p +: run_width_p]   = r_run;
                        w_run_nxt                             = '0;
                    end
                end else if (flush_i && (r_run != '0)) begin
                    // Flush only wins on idle cycles; the requester keeps it
                    // asserted until a cycle without an accept.
                    w_gen                  = 1'b1;
                    w_pkt[63:62]           = c_PT_RUN;
                    w_pkt[run_width_p-1:0] = r_run;
                    w_run_nxt              = '0;
                end
            end
            c_ST_DROP: begin
                if (w_full) begin
                    if (w_accept) begin
                        w_drop_nxt = w_drop_inc;
                    end
                end else begin
                    // The commit on the freeing cycle is counted, not encoded.
                    w_gen                   = 1'b1;
                    w_pkt[63:62]            = c_PT_OVERFLOW;
                    w_pkt[drop_width_p-1:0] = w_accept ? w_drop_inc : r_drop;
                    w_drop_nxt              = '0;
                    w_state_nxt             = c_ST_SYNC;
                end
            end
            default: begin
                w_state_nxt = c_ST_SYNC;
            end
        endcase

        // A packet meeting a full FIFO is lost; that commit is the first drop.
        if ((r_state != c_ST_DROP) && w_gen && w_full) begin
            w_drop_nxt  = drop_width_p'(1);
            w_run_nxt   = '0;
            w_state_nxt = c_ST_DROP;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= c_ST_SYNC;
            r_run     <= '0;
            r_last_pc <= '0;
            r_drop    <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_run     <= w_run_nxt;
            r_last_pc <= w_last_pc_nxt;
            r_drop    <= w_drop_nxt;
            if (w_enq) begin
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (w_deq) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an empty FIFO masks the head to zero.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wptr] <= w_pkt;
        end
    end

    assign trace_v_o    = ~w_empty;
    assign trace_data_o = w_empty ? 64'd0 : r_mem[r_rptr];
    assign overflow_o   = (r_state == c_ST_DROP);

endmodule
`default_nettype wire

// File: tb/tb_bp_trace_delta_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_trace_delta_encoder
//  Purpose  : Self-checking bench for bp_trace_delta_encoder. Expected packets
//             are queued as stimulus is driven and popped as the sink accepts
//             them. A narrow run counter and a two-entry FIFO make the
//             saturation and overflow paths reachable in a few cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bp_trace_delta_encoder;

    localparam int c_VA = 40;
    localparam int c_RW = 4;
    localparam int c_DW = 16;
    localparam int c_FE = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            commit_v;
    logic            commit_ready;
    logic [c_VA-1:0] commit_pc;
    logic            flush;
    logic [63:0]     trace_data;
    logic            trace_v;
    logic            trace_ready;
    logic            overflow;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [63:0]     sb [$];

    always #5 clk = ~clk;

    bp_trace_delta_encoder #(
        .vaddr_width_p (c_VA),
        .run_width_p   (c_RW),
        .drop_width_p  (c_DW),
        .fifo_els_p    (c_FE)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .commit_v_i     (commit_v),
        .commit_ready_i (commit_ready),
        .commit_pc_i    (commit_pc),
        .flush_i        (flush),
        .trace_data_o   (trace_data),
        .trace_v_o      (trace_v),
        .trace_ready_i  (trace_ready),
        .overflow_o     (overflow)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Sink side: handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (reset_n && trace_v && trace_ready) begin
            check_eq("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                check_eq("pkt", trace_data, sb.pop_front());
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        commit_v     = 1'b0;
        commit_ready = 1'b1;
        commit_pc    = '0;
        flush        = 1'b0;
        trace_ready  = 1'b1;
        sb.delete();
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic commit(input logic [c_VA-1:0] pc);
        commit_v  = 1'b1;
        commit_pc = pc;
        step(1);
        commit_v  = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step(1);
        flush = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        step(6);
        check_eq({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        check_eq({tag, "_v_low"}, 64'(trace_v), 64'd0);
    endtask

    initial begin
        do_reset();
        check_eq("rst_v", 64'(trace_v), 64'd0);
        check_eq("rst_data", trace_data, 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);

        // SYNC, two sequential commits, then a branch carrying run=2.
        check_eq("pre_sync_v", 64'(trace_v), 64'd0);
        sb.push_back(64'h0000_0000_0000_1000);
        commit(40'h10_00);
        check_eq("sync_latency_v", 64'(trace_v), 64'd1);
        commit(40'h10_04);
        commit(40'h10_08);
        sb.push_back(64'h8000_0200_0000_2000);
        commit(40'h20_00);
        drain_check("branch");

        // Flush emits the pending run once; an unaccepted commit is ignored.
        do_reset();
        sb.push_back(64'h0000_0000_0000_1000);
        commit(40'h10_00);
        commit(40'h10_04);
        commit_ready = 1'b0;
        commit(40'h55_55);
        commit_ready = 1'b1;
        commit(40'h10_08);
        commit(40'h10_0C);
        sb.push_back(64'h4000_0000_0000_0003);
        pulse_flush();
        step(2);
        pulse_flush();
        drain_check("flush");

        // Run counter saturation with a 4-bit run field.
        do_reset();
        sb.push_back(64'h0000_0000_0000_3000);
        commit(40'h30_00);
        for (int i = 1; i <= 14; i++) begin
            commit(40'h30_00 + 40'(4 * i));
        end
        sb.push_back(64'h4000_0000_0000_000F);
        commit(40'h30_3C);
        commit(40'h30_40);
        step(3);
        check_eq("run_restart_quiet", 64'(sb.size()), 64'd0);
        sb.push_back(64'h4000_0000_0000_0001);
        pulse_flush();
        drain_check("runsat");

        // Overflow: two packets fill the FIFO, the third is dropped.
        do_reset();
        trace_ready = 1'b0;
        sb.push_back(64'h0000_0000_0000_1000);
        commit(40'h10_00);
        sb.push_back(64'h8000_0000_0000_5000);
        commit(40'h50_00);
        check_eq("ovf_pre", 64'(overflow), 64'd0);
        commit(40'h90_00);
        check_eq("ovf_set", 64'(overflow), 64'd1);
        for (int i = 0; i < 4; i++) begin
            commit(40'hA0_00 + 40'(i * 16));
        end
        check_eq("ovf_hold_data", trace_data, 64'h0000_0000_0000_1000);
        check_eq("ovf_hold_v", 64'(trace_v), 64'd1);
        check_eq("ovf_still", 64'(overflow), 64'd1);
        sb.push_back(64'hC000_0000_0000_0005);
        trace_ready = 1'b1;
        step(4);
        check_eq("ovf_clear", 64'(overflow), 64'd0);
        sb.push_back(64'h0000_0000_0000_B000);
        commit(40'hB0_00);
        drain_check("ovf");

        // Address wrap counts as sequential.
        do_reset();
        sb.push_back(64'h0000_00FF_FFFF_FFFC);
        commit(40'hFF_FFFF_FFFC);
        commit(40'h00_0000_0000);
        commit(40'h00_0000_0004);
        sb.push_back(64'h4000_0000_0000_0002);
        pulse_flush();
        drain_check("wrap");

        // Asynchronous reset discards queued packets without a clock edge.
        do_reset();
        trace_ready = 1'b0;
        commit(40'h70_00);
        commit(40'h80_00);
        check_eq("prerst_v", 64'(trace_v), 64'd1);
        check_eq("prerst_data", trace_data, 64'h0000_0000_0000_7000);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_v", 64'(trace_v), 64'd0);
        check_eq("async_rst_data", trace_data, 64'd0);
        sb.delete();
        step(1);
        reset_n     = 1'b1;
        trace_ready = 1'b1;
        step(1);
        sb.push_back(64'h0000_0000_0000_0100);
        commit(40'h01_00);
        drain_check("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
